phys_reg_file_bp: RTL and testbench

//  Parametrised multi-port physical register file for the OoO core, with a per-preg ready scoreboard.

---
 rtl/CDB_types.sv | 21 ++
 rtl/phys_reg_file_bp_if.sv | 49 ++++
 rtl/prf_ready_table.sv | 72 +++++++
 rtl/phys_reg_file_bp.sv | 130 +++++++++++++
 tb/tb_phys_reg_file_bp.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/CDB_types.sv
// Shared sizing for the physical register file and the common data bus.
// Contents:
//   P_REG_NUM     - number of physical registers (power of 2, index 0 is the zero register)
//   CDB_NUM       - number of CDB write ports
//   PRF_IDX_W     - width of a physical register index
//   PRF_DATA_W    - register data width
//   PRF_NUM_RD    - number of rs1/rs2 read-port pairs
//   PRF_NUM_ALLOC - rename allocations per cycle
//   prf_idx_t     - physical register index type
package CDB_types;

  localparam int P_REG_NUM     = 64;
  localparam int CDB_NUM       = 5;
  localparam int PRF_IDX_W     = $clog2(P_REG_NUM);
  localparam int PRF_DATA_W    = 32;
  localparam int PRF_NUM_RD    = 5;
  localparam int PRF_NUM_ALLOC = 1;

  typedef logic [PRF_IDX_W-1:0] prf_idx_t;

endpackage

// File: rtl/phys_reg_file_bp_if.sv
// Bus between rename/dispatch + CDB (master) and the physical register file (slave).
// Signals:
//   wr_en/wr_pd/wr_data     CDB writeback, one lane per write port
//   alloc_en/alloc_pd       rename allocation, clears the ready bit of alloc_pd
//   flush                   pipeline squash, marks every preg ready
//   rd_en/rs1_s/rs2_s       read request per pair
//   rd_valid/rs*_v/rs*_rdy  registered read response per pair
// Handshake: there is no back-pressure. A read request is accepted in every cycle
// rd_en[p] is high; exactly one cycle later rd_valid[p] is high for one cycle and
// rs1_v/rs2_v/rs1_rdy/rs2_rdy[p] carry the response. While rd_valid[p] is low the
// data lanes of that pair hold their last response.
interface phys_reg_file_bp_if
  import CDB_types::*;
#(
  parameter int NUM_PREG  = P_REG_NUM,
  parameter int DATA_W    = PRF_DATA_W,
  parameter int NUM_WR    = CDB_NUM,
  parameter int NUM_RD    = PRF_NUM_RD,
  parameter int NUM_ALLOC = PRF_NUM_ALLOC
);

  localparam int IDX_W = $clog2(NUM_PREG);

  logic [NUM_WR-1:0]                 wr_en;
  logic [NUM_WR-1:0][IDX_W-1:0]      wr_pd;
  logic [NUM_WR-1:0][DATA_W-1:0]     wr_data;
  logic [NUM_ALLOC-1:0]              alloc_en;
  logic [NUM_ALLOC-1:0][IDX_W-1:0]   alloc_pd;
  logic                              flush;
  logic [NUM_RD-1:0]                 rd_en;
  logic [NUM_RD-1:0][IDX_W-1:0]      rs1_s;
  logic [NUM_RD-1:0][IDX_W-1:0]      rs2_s;
  logic [NUM_RD-1:0]                 rd_valid;
  logic [NUM_RD-1:0][DATA_W-1:0]     rs1_v;
  logic [NUM_RD-1:0][DATA_W-1:0]     rs2_v;
  logic [NUM_RD-1:0]                 rs1_rdy;
  logic [NUM_RD-1:0]                 rs2_rdy;

  modport master (
    output wr_en, wr_pd, wr_data, alloc_en, alloc_pd, flush, rd_en, rs1_s, rs2_s,
    input  rd_valid, rs1_v, rs2_v, rs1_rdy, rs2_rdy
  );

  modport slave (
    input  wr_en, wr_pd, wr_data, alloc_en, alloc_pd, flush, rd_en, rs1_s, rs2_s,
    output rd_valid, rs1_v, rs2_v, rs1_rdy, rs2_rdy
  );

endinterface

// File: rtl/prf_ready_table.sv
// Per-preg ready scoreboard with registered lookup.
// Update priority per bit (lowest to highest): hold, CDB write sets, alloc clears,
// flush sets all. Index 0 is never written or allocated, so it stays ready.
// Ports:
//   clk, rst      clock, synchronous active-high reset (all bits ready, lookups 0)
//   i_wr_en/pd    CDB writes (set the ready bit, pd 0 ignored)
//   i_alloc_en/pd allocations (clear the ready bit, pd 0 ignored)
//   i_flush       set every ready bit
//   i_lk_en       per-source lookup enable; a disabled lookup holds its output
//   i_lk_src      per-source preg index
//   i_lk_force    per-source forced-ready (same-cycle bypass hit)
//   o_lk_rdy      registered ready bit per source
module prf_ready_table #(
  parameter int NUM_PREG  = 64,
  parameter int NUM_WR    = 5,
  parameter int NUM_ALLOC = 1,
  parameter int NUM_SRC   = 10,
  parameter int IDX_W     = $clog2(NUM_PREG)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               i_wr_en,
  input  logic [NUM_WR-1:0][IDX_W-1:0]    i_wr_pd,
  input  logic [NUM_ALLOC-1:0]            i_alloc_en,
  input  logic [NUM_ALLOC-1:0][IDX_W-1:0] i_alloc_pd,
  input  logic                            i_flush,
  input  logic [NUM_SRC-1:0]              i_lk_en,
  input  logic [NUM_SRC-1:0][IDX_W-1:0]   i_lk_src,
  input  logic [NUM_SRC-1:0]              i_lk_force,
  output logic [NUM_SRC-1:0]              o_lk_rdy
);

  logic [NUM_PREG-1:0] r_ready;
  logic [NUM_PREG-1:0] w_ready_nxt;
  logic [NUM_SRC-1:0]  r_lk_rdy;

  always_comb begin
    w_ready_nxt = r_ready;
    for (int w = 0; w < NUM_WR; w++) begin
      if (i_wr_en[w] && (i_wr_pd[w] != '0)) begin
        w_ready_nxt[i_wr_pd[w]] = 1'b1;
      end
    end
    // Alloc after write: a preg written and re-allocated in one cycle ends not ready.
    for (int a = 0; a < NUM_ALLOC; a++) begin
      if (i_alloc_en[a] && (i_alloc_pd[a] != '0)) begin
        w_ready_nxt[i_alloc_pd[a]] = 1'b0;
      end
    end
    if (i_flush) begin
      w_ready_nxt = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready  <= '1;
      r_lk_rdy <= '0;
    end else begin
      r_ready <= w_ready_nxt;
      // Lookup uses the pre-edge bit; a bypass hit forces it ready.
      for (int s = 0; s < NUM_SRC; s++) begin
        if (i_lk_en[s]) begin
          r_lk_rdy[s] <= i_lk_force[s] | r_ready[i_lk_src[s]];
        end
      end
    end
  end

  assign o_lk_rdy = r_lk_rdy;

endmodule

// File: rtl/phys_reg_file_bp.sv
// Multi-port physical register file with per-preg ready scoreboard.
// Optional feature macro: PRF_BYPASS_EN
//   defined   - a read whose source matches a same-cycle CDB write returns the
//               write data and ready=1 (highest write port wins)
//   undefined - reads return the pre-edge data and ready bit
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (data 0, ready 1, read outputs 0)
//   bus  phys_reg_file_bp_if.slave: CDB writes, allocs, flush, read pairs and
//        their 1-cycle registered responses
module phys_reg_file_bp
  import CDB_types::*;
#(
  parameter int NUM_PREG  = P_REG_NUM,
  parameter int DATA_W    = PRF_DATA_W,
  parameter int NUM_WR    = CDB_NUM,
  parameter int NUM_RD    = PRF_NUM_RD,
  parameter int NUM_ALLOC = PRF_NUM_ALLOC
) (
  input  logic               clk,
  input  logic               rst,
  phys_reg_file_bp_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_PREG);

  logic [DATA_W-1:0]               r_data [NUM_PREG];
  logic [NUM_RD-1:0]               r_rd_valid;
  logic [NUM_RD-1:0][DATA_W-1:0]   r_rs1_v;
  logic [NUM_RD-1:0][DATA_W-1:0]   r_rs2_v;

  logic [NUM_RD-1:0][DATA_W-1:0]   w_rs1_val;
  logic [NUM_RD-1:0][DATA_W-1:0]   w_rs2_val;
  logic [NUM_RD-1:0]               w_rs1_hit;
  logic [NUM_RD-1:0]               w_rs2_hit;
  logic [2*NUM_RD-1:0]             w_lk_en;
  logic [2*NUM_RD-1:0][IDX_W-1:0]  w_lk_src;
  logic [2*NUM_RD-1:0]             w_lk_force;
  logic [2*NUM_RD-1:0]             w_lk_rdy;

  // Data array. Ports are scanned low to high so the highest port's
  // non-blocking update is the one that lands on a shared pd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUM_PREG; p++) begin
        r_data[p] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_pd[w] != '0)) begin
          r_data[bus.wr_pd[w]] <= bus.wr_data[w];
        end
      end
    end
  end

  // Read mux (plus optional bypass). r_data[0] is never written, so source 0 reads 0.
  always_comb begin
    w_rs1_val = '0;
    w_rs2_val = '0;
    w_rs1_hit = '0;
    w_rs2_hit = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      w_rs1_val[p] = r_data[bus.rs1_s[p]];
      w_rs2_val[p] = r_data[bus.rs2_s[p]];
`ifdef PRF_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++) begin
        if (bus.wr_en[w] && (bus.wr_pd[w] != '0)) begin
          if (bus.wr_pd[w] == bus.rs1_s[p]) begin
            w_rs1_val[p] = bus.wr_data[w];
            w_rs1_hit[p] = 1'b1;
          end
          if (bus.wr_pd[w] == bus.rs2_s[p]) begin
            w_rs2_val[p] = bus.wr_data[w];
            w_rs2_hit[p] = 1'b1;
          end
        end
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= '0;
      r_rs1_v    <= '0;
      r_rs2_v    <= '0;
    end else begin
      r_rd_valid <= bus.rd_en;
      for (int p = 0; p < NUM_RD; p++) begin
        if (bus.rd_en[p]) begin
          r_rs1_v[p] <= w_rs1_val[p];
          r_rs2_v[p] <= w_rs2_val[p];
        end
      end
    end
  end

  // Lookup lanes: [NUM_RD-1:0] are rs1 of each pair, [2*NUM_RD-1:NUM_RD] are rs2.
  assign w_lk_en    = {bus.rd_en, bus.rd_en};
  assign w_lk_src   = {bus.rs2_s, bus.rs1_s};
  assign w_lk_force = {w_rs2_hit, w_rs1_hit};

  prf_ready_table #(
    .NUM_PREG  (NUM_PREG),
    .NUM_WR    (NUM_WR),
    .NUM_ALLOC (NUM_ALLOC),
    .NUM_SRC   (2*NUM_RD),
    .IDX_W     (IDX_W)
  ) u_ready (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (bus.wr_en),
    .i_wr_pd    (bus.wr_pd),
    .i_alloc_en (bus.alloc_en),
    .i_alloc_pd (bus.alloc_pd),
    .i_flush    (bus.flush),
    .i_lk_en    (w_lk_en),
    .i_lk_src   (w_lk_src),
    .i_lk_force (w_lk_force),
    .o_lk_rdy   (w_lk_rdy)
  );

  assign bus.rd_valid = r_rd_valid;
  assign bus.rs1_v    = r_rs1_v;
  assign bus.rs2_v    = r_rs2_v;
  assign bus.rs1_rdy  = w_lk_rdy[NUM_RD-1:0];
  assign bus.rs2_rdy  = w_lk_rdy[2*NUM_RD-1:NUM_RD];

endmodule

// File: tb/tb_phys_reg_file_bp.sv
module tb_phys_reg_file_bp;
  import CDB_types::*;

  localparam int W = 3 + 32 + 1 + 32 + 1;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [W-1:0] exp_q[$];

  phys_reg_file_bp_if bus ();

  phys_reg_file_bp dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic clr();
    bus.wr_en    = '0;
    bus.wr_pd    = '0;
    bus.wr_data  = '0;
    bus.alloc_en = '0;
    bus.alloc_pd = '0;
    bus.flush    = 1'b0;
    bus.rd_en    = '0;
    bus.rs1_s    = '0;
    bus.rs2_s    = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic wr(input int port, input int pd, input logic [31:0] d);
    bus.wr_en[port]   = 1'b1;
    bus.wr_pd[port]   = prf_idx_t'(pd);
    bus.wr_data[port] = d;
  endtask

  task automatic alloc(input int pd);
    bus.alloc_en[0] = 1'b1;
    bus.alloc_pd[0] = prf_idx_t'(pd);
  endtask

  // Issue a read on pair p and queue its hand-computed response.
  // Within one cycle, call in ascending pair order.
  task automatic rd(input int p, input int s1, input int s2,
                    input logic [31:0] v1, input logic r1,
                    input logic [31:0] v2, input logic r2);
    bus.rd_en[p] = 1'b1;
    bus.rs1_s[p] = prf_idx_t'(s1);
    bus.rs2_s[p] = prf_idx_t'(s2);
    exp_q.push_back({3'(p), v1, r1, v2, r2});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    for (int p = 0; p < PRF_NUM_RD; p++) begin
      if (bus.rd_valid[p] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rd_valid pair %0d", p);
        end else begin
          e   = exp_q.pop_front();
          got = {3'(p), bus.rs1_v[p], bus.rs1_rdy[p], bus.rs2_v[p], bus.rs2_rdy[p]};
          if (got !== e) begin
            errors++;
            $display("FAIL read_resp pair %0d got p=%0d v1=0x%0h r1=%0b v2=0x%0h r2=%0b expected p=%0d v1=0x%0h r1=%0b v2=0x%0h r2=%0b",
                     p, got[68:66], got[65:34], got[33], got[32:1], got[0],
                     e[68:66], e[65:34], e[33], e[32:1], e[0]);
          end
        end
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rs1_v0",   bus.rs1_v[0], 32'd0);
    chk("reset_rs1_rdy",  32'(bus.rs1_rdy), 32'd0);
    chk("reset_rs2_rdy",  32'(bus.rs2_rdy), 32'd0);

    // 1: fresh pregs read as 0 / ready
    tick();
    rd(0, 5, 6, 32'h0, 1'b1, 32'h0, 1'b1);
    rd(1, 7, 8, 32'h0, 1'b1, 32'h0, 1'b1);
    tick();
    repeat ($urandom_range(0, 2)) tick();

    // 2: alloc clears ready, CDB write sets it
    alloc(9);
    tick();
    rd(2, 9, 0, 32'h0, 1'b0, 32'h0, 1'b1);
    tick();
    wr(2, 9, 32'hDEADBEEF);
    tick();
    rd(4, 9, 9, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1);
    tick();

    // 3: highest write port wins; writes to pd 0 are dropped
    wr(0, 12, 32'h11);
    wr(1, 0, 32'h55);
    wr(4, 12, 32'h44);
    tick();
    rd(0, 12, 0, 32'h44, 1'b1, 32'h0, 1'b1);
    tick();

    // hold: outputs keep last response while rd_en is low
    rd(1, 9, 12, 32'hDEADBEEF, 1'b1, 32'h44, 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("hold_rd_valid1", 32'(bus.rd_valid[1]), 32'd0);
    chk("hold_rs1_v1",    bus.rs1_v[1], 32'hDEADBEEF);
    chk("hold_rs2_v1",    bus.rs2_v[1], 32'h44);

    // 4: same-cycle write + read
    alloc(20);
    tick();
    wr(1, 20, 32'hABCD);
`ifdef PRF_BYPASS_EN
    rd(3, 20, 20, 32'hABCD, 1'b1, 32'hABCD, 1'b1);
`else
    rd(3, 20, 20, 32'h0, 1'b0, 32'h0, 1'b0);
`endif
    tick();
    rd(3, 20, 20, 32'hABCD, 1'b1, 32'hABCD, 1'b1);
    tick();
    // bypass precedence among write ports
    wr(0, 21, 32'h1);
    wr(3, 21, 32'h3);
`ifdef PRF_BYPASS_EN
    rd(4, 21, 21, 32'h3, 1'b1, 32'h3, 1'b1);
`else
    rd(4, 21, 21, 32'h0, 1'b1, 32'h0, 1'b1);
`endif
    tick();
    rd(4, 21, 0, 32'h3, 1'b1, 32'h0, 1'b1);
    tick();
    // alloc beats write on the ready bit; data still lands
    alloc(22);
    wr(2, 22, 32'h22);
    tick();
    rd(0, 22, 22, 32'h22, 1'b0, 32'h22, 1'b0);
    tick();
    // same-cycle alloc does not suppress the bypass
    alloc(23);
    wr(0, 23, 32'h23);
`ifdef PRF_BYPASS_EN
    rd(2, 23, 23, 32'h23, 1'b1, 32'h23, 1'b1);
`else
    rd(2, 23, 23, 32'h0, 1'b1, 32'h0, 1'b1);
`endif
    tick();
    rd(2, 23, 0, 32'h23, 1'b0, 32'h0, 1'b1);
    tick();

    // 5: flush sets all ready bits and overrides a same-cycle alloc
    alloc(30);
    tick();
    alloc(31);
    tick();
    rd(0, 30, 31, 32'h0, 1'b0, 32'h0, 1'b0);
    tick();
    bus.flush = 1'b1;
    alloc(32);
    tick();
    rd(0, 30, 31, 32'h0, 1'b1, 32'h0, 1'b1);
    rd(1, 32, 32, 32'h0, 1'b1, 32'h0, 1'b1);
    tick();
    drain("drain_before_reset");

    // 6: read issued together with reset is dropped, outputs cleared
    rst = 1'b1;
    bus.rd_en[3] = 1'b1;
    bus.rs1_s[3] = prf_idx_t'(9);
    bus.rs2_s[3] = prf_idx_t'(20);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rd_valid3", 32'(bus.rd_valid[3]), 32'd0);
    chk("rst_rs1_v3",    bus.rs1_v[3], 32'd0);
    chk("rst_rs2_v3",    bus.rs2_v[3], 32'd0);
    chk("rst_rs1_rdy3",  32'(bus.rs1_rdy[3]), 32'd0);
    chk("rst_rs2_rdy3",  32'(bus.rs2_rdy[3]), 32'd0);
    // data and ready restored to reset values
    rd(3, 9, 22, 32'h0, 1'b1, 32'h0, 1'b1);
    tick();
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
